// File: rtl/dcf77_encoder.sv
// DCF77 time-code envelope generator: a shadow register captures the date/time on load and
// is copied into the transmit frame at every minute boundary; dcf_out = 1 means reduced carrier.
module dcf77_encoder #(
  parameter int tick_div = 10000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        load,
  input  logic [13:0] broadcast,
  input  logic        r,
  input  logic        a1,
  input  logic        z1,
  input  logic        z2,
  input  logic        a2,
  input  logic [7:0]  minute,
  input  logic [7:0]  hour,
  input  logic [7:0]  day,
  input  logic [2:0]  day_of_week,
  input  logic [7:0]  month,
  input  logic [7:0]  year,
  output logic        dcf_out,
  output logic [5:0]  second,
  output logic        frame_start,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  localparam int            PW         = $clog2(tick_div);
  localparam logic [PW-1:0] PRESC_LAST = PW'(tick_div - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [9:0]    ms_q, ms_d;
  logic [5:0]    sec_q, sec_d;
  logic [58:0]   shadow_q, shadow_new;
  logic [58:0]   frame_q, frame_d;
  logic          dcf_q, dcf_d;
  logic          fs_q, fs_d;

  logic          tick, ms_wrap, cur_bit;
  logic          p1, p2, p3;
  logic          unused_bits;

  // Parity is even over the BCD groups exactly as they appear in the frame.
  assign p1 = ^minute[6:0];
  assign p2 = ^hour[5:0];
  assign p3 = ^{year, month[4:0], day_of_week, day[5:0]};
  assign unused_bits = ^{minute[7], hour[7:6], day[7:6], month[7:5]};

  assign shadow_new = {p3, year, month[4:0], day_of_week, day[5:0], p2, hour[5:0], p1,
                       minute[6:0], 1'b1, a2, z2, z1, a1, r, broadcast, 1'b0};

  assign tick    = (presc_q == PRESC_LAST);
  assign ms_wrap = tick && (ms_q == 10'd999);
  assign cur_bit = (sec_q <= 6'd58) ? frame_q[sec_q] : 1'b0;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    ms_d    = ms_q;
    sec_d   = sec_q;
    frame_d = frame_q;
    fs_d    = 1'b0;
    dcf_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        presc_d = '0;
        ms_d    = '0;
        sec_d   = '0;
        if (enable) state_d = ST_START;
      end
      ST_START: begin
        // Transmission always opens with a full minute mark.
        presc_d = '0;
        ms_d    = '0;
        sec_d   = 6'd59;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!enable) begin
          state_d = ST_IDLE;
          presc_d = '0;
          ms_d    = '0;
          sec_d   = '0;
        end else begin
          presc_d = tick ? '0 : presc_q + 1'b1;
          if (tick) ms_d = ms_wrap ? 10'd0 : ms_q + 10'd1;
          if (ms_wrap) begin
            if (sec_q == 6'd59) begin
              sec_d   = '0;
              frame_d = shadow_q;
              fs_d    = 1'b1;
            end else begin
              sec_d = sec_q + 6'd1;
            end
          end
          dcf_d = (sec_q <= 6'd58) && (ms_q < (cur_bit ? 10'd200 : 10'd100));
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      presc_q  <= '0;
      ms_q     <= '0;
      sec_q    <= '0;
      shadow_q <= '0;
      frame_q  <= '0;
      dcf_q    <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      ms_q    <= ms_d;
      sec_q   <= sec_d;
      frame_q <= frame_d;
      dcf_q   <= dcf_d;
      fs_q    <= fs_d;
      if (load) shadow_q <= shadow_new;
    end
  end

  assign dcf_out     = dcf_q;
  assign second      = sec_q;
  assign frame_start = fs_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_dcf77_encoder.sv
// Bench for dcf77_encoder: a tick_div=4 instance for mark/frame/enable/reset behaviour and a
// tick_div=2 instance for load-on-wrap and frame spacing, running side by side.
`timescale 1ns/1ps
module tb_dcf77_encoder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst4, rst2, en4, en2, ld4, ld2;
  logic [13:0] broadcast;
  logic        r, a1, z1, z2, a2;
  logic [7:0]  minute, hour, day, month, year;
  logic [2:0]  dow;
  logic        dcf4, dcf2, fs4, fs2;
  logic [5:0]  sec4, sec2;
  logic [1:0]  st4, st2;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;
  int     fs2_count = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (fs2) fs2_count <= fs2_count + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;

  // minute 0x34, hour 0x12, day 0x15, dow 3, month 0x06, year 0x24, z1=1; P1=1, P2=0, P3=1
  localparam logic [58:0] FRAME_A = {1'b1, 4'b0010, 4'b0100, 1'b0, 4'b0110, 3'b011,
                                     2'b01, 4'b0101, 1'b0, 2'b01, 4'b0010, 1'b1,
                                     3'b011, 4'b0100, 1'b1, 5'b00100, 14'b0, 1'b0};
  // same with minute 0x35: P1=0
  localparam logic [58:0] FRAME_B = {1'b1, 4'b0010, 4'b0100, 1'b0, 4'b0110, 3'b011,
                                     2'b01, 4'b0101, 1'b0, 2'b01, 4'b0010, 1'b0,
                                     3'b011, 4'b0101, 1'b1, 5'b00100, 14'b0, 1'b0};

  dcf77_encoder #(.tick_div(4)) dut4 (
    .clk(clk), .rst(rst4), .enable(en4), .load(ld4), .broadcast(broadcast),
    .r(r), .a1(a1), .z1(z1), .z2(z2), .a2(a2), .minute(minute), .hour(hour),
    .day(day), .day_of_week(dow), .month(month), .year(year),
    .dcf_out(dcf4), .second(sec4), .frame_start(fs4), .state_dbg(st4)
  );

  dcf77_encoder #(.tick_div(2)) dut2 (
    .clk(clk), .rst(rst2), .enable(en2), .load(ld2), .broadcast(broadcast),
    .r(r), .a1(a1), .z1(z1), .z2(z2), .a2(a2), .minute(minute), .hour(hour),
    .day(day), .day_of_week(dow), .month(month), .year(year),
    .dcf_out(dcf2), .second(sec2), .frame_start(fs2), .state_dbg(st2)
  );

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic dcf_of(input int idx);
    return (idx == 0) ? dcf4 : dcf2;
  endfunction

  function automatic logic [5:0] sec_of(input int idx);
    return (idx == 0) ? sec4 : sec2;
  endfunction

  // Scoreboard: expected pulse widths per second, popped as each pulse is measured.
  task automatic measure_frame(input int idx, input logic [58:0] fr, input int td, input string tag);
    logic [15:0] exp_q[$];
    int waited;
    int w;
    for (int s = 0; s < 59; s++) exp_q.push_back(fr[s] ? 16'(200 * td) : 16'(100 * td));
    for (int s = 0; s < 59; s++) begin
      waited = 0;
      while (!dcf_of(idx) && waited < 1000 * td + 10) begin
        @(negedge clk);
        waited++;
      end
      check($sformatf("%s_rise%0d", tag, s), dcf_of(idx), 1'b1);
      if (!dcf_of(idx)) return;
      check($sformatf("%s_sec%0d", tag, s), sec_of(idx), s);
      w = 0;
      while (dcf_of(idx) && w < 300 * td) begin
        w++;
        @(negedge clk);
      end
      check($sformatf("%s_w%0d", tag, s), w, exp_q.pop_front());
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic flow4();
    int bad;
    int n;
    logic saw;
    en4 = 1'b1;
    @(negedge clk);
    check("start_state", st4, S_START);
    check("start_sec", sec4, 0);
    @(negedge clk);
    check("run_state", st4, S_RUN);
    check("mark_sec", sec4, 59);
    bad = 0;
    for (int i = 1; i < 4000; i++) begin
      @(negedge clk);
      if (sec4 != 6'd59 || dcf4 || fs4) bad++;
    end
    check("mark_hold", bad, 0);
    @(negedge clk);
    check("fs4_first", fs4, 1'b1);
    check("fs4_sec0", sec4, 0);
    @(negedge clk);
    check("fs4_one_cycle", fs4, 1'b0);
    measure_frame(0, FRAME_A, 4, "a4");
    n = 0;
    saw = 1'b0;
    while (!fs4 && n < 10000) begin
      if (dcf4) saw = 1'b1;
      @(negedge clk);
      n++;
    end
    check("no_pulse_59", saw, 1'b0);
    check("fs4_second", fs4, 1'b1);
    // second 10, ms 50: inside the 100 ms pulse
    repeat (40200) @(negedge clk);
    check("dis_sec", sec4, 10);
    check("dis_dcf_before", dcf4, 1'b1);
    en4 = 1'b0;
    @(negedge clk);
    check("dis_dcf_after", dcf4, 1'b0);
    check("dis_state", st4, S_IDLE);
    check("dis_sec_clear", sec4, 0);
    en4 = 1'b1;
    @(negedge clk);
    check("re_start", st4, S_START);
    @(negedge clk);
    check("re_sec59", sec4, 59);
    check("re_dcf", dcf4, 1'b0);
    repeat (24200) @(negedge clk);
    check("rst_pre_sec", sec4, 5);
    check("rst_pre_dcf", dcf4, 1'b1);
    #2 rst4 = 1'b0;
    #1;
    check("rst_async_dcf", dcf4, 1'b0);
    check("rst_async_sec", sec4, 0);
    check("rst_async_fs", fs4, 1'b0);
    check("rst_async_state", st4, S_IDLE);
    @(negedge clk);
    en4 = 1'b0;
    rst4 = 1'b1;
    @(negedge clk);
    check("rst_release_state", st4, S_IDLE);
    check("rst_release_sec", sec4, 0);
  endtask

  task automatic flow2();
    longint t1;
    longint t2;
    en2 = 1'b1;
    repeat (2001) @(negedge clk);
    check("wrap2_pre_sec", sec2, 59);
    check("wrap2_pre_fs", fs2, 1'b0);
    minute = 8'h35;
    ld2 = 1'b1;
    @(negedge clk);
    ld2 = 1'b0;
    check("wrap2_fs", fs2, 1'b1);
    check("wrap2_sec", sec2, 0);
    t1 = cyc;
    measure_frame(1, FRAME_A, 2, "a2");
    while (cyc < t1 + 119999) @(negedge clk);
    @(negedge clk);
    check("fs2_interval1", fs2, 1'b1);
    t2 = cyc;
    measure_frame(1, FRAME_B, 2, "b2");
    while (cyc < t2 + 119999) @(negedge clk);
    @(negedge clk);
    check("fs2_interval2", fs2, 1'b1);
    @(negedge clk);
    check("fs2_count", fs2_count, 3);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst4 = 1'b0; rst2 = 1'b0; en4 = 1'b0; en2 = 1'b0; ld4 = 1'b0; ld2 = 1'b0;
    broadcast = '0; r = 1'b0; a1 = 1'b0; z1 = 1'b0; z2 = 1'b0; a2 = 1'b0;
    minute = '0; hour = '0; day = '0; dow = '0; month = '0; year = '0;
    repeat (3) @(negedge clk);
    check("reset_dcf", dcf4, 1'b0);
    check("reset_sec", sec4, 0);
    check("reset_fs", fs4, 1'b0);
    check("reset_state", st4, S_IDLE);
    check("reset_state2", st2, S_IDLE);
    rst4 = 1'b1;
    rst2 = 1'b1;
    minute = 8'h34; hour = 8'h12; day = 8'h15; dow = 3'd3; month = 8'h06; year = 8'h24;
    z1 = 1'b1;
    ld4 = 1'b1;
    ld2 = 1'b1;
    @(negedge clk);
    ld4 = 1'b0;
    ld2 = 1'b0;
    @(negedge clk);
    check("idle_hold_state", st4, S_IDLE);
    check("idle_hold_dcf", dcf4, 1'b0);
    fork
      flow4();
      flow2();
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
